// File: rtl/fp_seq_adder.sv
// fp_seq_adder: multi-cycle floating-point adder (IDLE/ALIGN/ADD/NORM/DONE).
// One operation in flight, valid/ready on both sides, truncating rounding.
// Optional feature: define FP_SEQ_ADDER_SUB_EN to add a 'sub' port (a - b).
module fp_seq_adder #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef FP_SEQ_ADDER_SUB_EN
  input  logic                   sub,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO  = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0] MAN_W_E   = EXP_W'(MAN_W);
  localparam logic [MAN_W-1:0] MAN_ZERO  = {MAN_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_r;
  logic [W-1:0]       a_r, b_r, result_r;
  logic               in_ready_r, out_valid_r;
  logic               sign_r, eff_sub_r;
  logic [EXP_W-1:0]   exp_r;
  logic [MAN_W:0]     man_l_r;   // L mantissa with hidden bit; reused as NORM working mantissa
  logic [MAN_W:0]     man_s_r;   // aligned S mantissa

  logic               sign_a_s, sign_b_s, sign_l_s, sign_s_s;
  logic [EXP_W-1:0]   exp_a_s, exp_b_s, exp_l_s, exp_s_s, d_s, exp_inc_s, exp_dec_s;
  logic [MAN_W-1:0]   man_a_s, man_b_s, man_l_s, man_s_s;
  logic               a_gt_b_s, same_mag_s;
  logic [MAN_W:0]     man_s_shift_s, man_shl_s;
  logic [MAN_W+1:0]   sum_s;
  logic               b_sign_in_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;

`ifdef FP_SEQ_ADDER_SUB_EN
  assign b_sign_in_s = b[W-1] ^ sub;
`else
  assign b_sign_in_s = b[W-1];
`endif

  // Operand decode, L/S selection, alignment shift and mantissa add/sub.
  always_comb begin
    sign_a_s = a_r[W-1];
    exp_a_s  = a_r[W-2:MAN_W];
    man_a_s  = a_r[MAN_W-1:0];
    sign_b_s = b_r[W-1];
    exp_b_s  = b_r[W-2:MAN_W];
    man_b_s  = b_r[MAN_W-1:0];
    a_gt_b_s   = {exp_a_s, man_a_s} > {exp_b_s, man_b_s};
    same_mag_s = {exp_a_s, man_a_s} == {exp_b_s, man_b_s};
    if (a_gt_b_s) begin
      sign_l_s = sign_a_s; exp_l_s = exp_a_s; man_l_s = man_a_s;
      sign_s_s = sign_b_s; exp_s_s = exp_b_s; man_s_s = man_b_s;
    end else begin
      sign_l_s = sign_b_s; exp_l_s = exp_b_s; man_l_s = man_b_s;
      sign_s_s = sign_a_s; exp_s_s = exp_a_s; man_s_s = man_a_s;
    end
    d_s = exp_l_s - exp_s_s;
    if (d_s > MAN_W_E) begin
      man_s_shift_s = {(MAN_W+1){1'b0}};
    end else begin
      man_s_shift_s = {1'b1, man_s_s} >> d_s;
    end
    if (eff_sub_r) begin
      sum_s = {1'b0, man_l_r} - {1'b0, man_s_r};
    end else begin
      sum_s = {1'b0, man_l_r} + {1'b0, man_s_r};
    end
    exp_inc_s = exp_r + EXP_ONE;
    exp_dec_s = exp_r - EXP_ONE;
    man_shl_s = {man_l_r[MAN_W-1:0], 1'b0};
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {W{1'b0}};
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      sign_r      <= 1'b0;
      eff_sub_r   <= 1'b0;
      exp_r       <= EXP_ZERO;
      man_l_r     <= {(MAN_W+1){1'b0}};
      man_s_r     <= {(MAN_W+1){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= {b_sign_in_s, b[W-2:0]};
            in_ready_r <= 1'b0;
            state_r    <= ALIGN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ALIGN: begin
          if (exp_a_s == EXP_ZERO) begin
            result_r    <= (exp_b_s == EXP_ZERO) ? {W{1'b0}} : b_r;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (exp_b_s == EXP_ZERO) begin
            result_r    <= a_r;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (same_mag_s && (sign_a_s != sign_b_s)) begin
            result_r    <= {W{1'b0}};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            sign_r    <= sign_l_s;
            eff_sub_r <= sign_l_s ^ sign_s_s;
            exp_r     <= exp_l_s;
            man_l_r   <= {1'b1, man_l_s};
            man_s_r   <= man_s_shift_s;
            state_r   <= ADD;
          end
        end
        ADD: begin
          if (sum_s[MAN_W+1]) begin
            // Carry: renormalise right by one; overflow saturates to infinity.
            if ((exp_inc_s == EXP_ONES) || (exp_r == EXP_ONES)) begin
              result_r <= {sign_r, EXP_ONES, MAN_ZERO};
            end else begin
              result_r <= {sign_r, exp_inc_s, sum_s[MAN_W:1]};
            end
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (sum_s[MAN_W]) begin
            result_r    <= {sign_r, exp_r, sum_s[MAN_W-1:0]};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            man_l_r <= sum_s[MAN_W:0];
            state_r <= NORM;
          end
        end
        NORM: begin
          if (exp_r == EXP_ONE) begin
            // Exponent would reach zero before normalising: flush to signed zero.
            result_r    <= {sign_r, EXP_ZERO, MAN_ZERO};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (man_shl_s[MAN_W]) begin
            result_r    <= {sign_r, exp_dec_s, man_shl_s[MAN_W-1:0]};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            man_l_r <= man_shl_s;
            exp_r   <= exp_dec_s;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_seq_adder.sv
// Scoreboard bench for fp_seq_adder: directed vectors with hand-computed results
// and accept-to-out_valid latencies; a monitor pops and compares on each result.
module tb_fp_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        sub;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat_cnt = 0;
  logic ov_seen = 1'b0;

  fp_seq_adder #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FP_SEQ_ADDER_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency counter: 1 on the accept edge, +1 on every following edge.
  always @(posedge clk) begin
    if (!rst_n) lat_cnt <= 0;
    else if (in_valid && in_ready) lat_cnt <= 1;
    else if (lat_cnt != 0) lat_cnt <= lat_cnt + 1;
  end

  // Monitor: on each new result, pop the scoreboard and compare.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !ov_seen) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %h with empty scoreboard", result);
      end else begin
        e = sb_q.pop_front();
        if (result !== e.res) begin
          errors++;
          $display("FAIL result: got %h expected %h", result, e.res);
        end
        checks++;
        if (lat_cnt != e.lat) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d (result %h)", lat_cnt, e.lat, e.res);
        end
      end
    end
    ov_seen = rst_n && out_valid;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic wait_out(input logic level);
    int n = 0;
    while (out_valid !== level && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== level) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got %b expected %b", out_valid, level);
    end
  endtask

  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vsub,
                       input logic [31:0] want, input int lat);
    exp_t e;
    wait_ready();
    e.res = want;
    e.lat = lat;
    sb_q.push_back(e);
    a = va; b = vb; sub = vsub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vsub,
                        input logic [31:0] want, input int lat);
    issue(va, vb, vsub, want, lat);
    wait_out(1'b1);
    wait_out(1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0;
    a = 32'h0; b = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'h0);
    rst_n = 1'b1;

    // Normal add, carry, special cases, NORM shifts, truncation, underflow.
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3);
    run_op(32'h3FC0_0000, 32'hBF80_0000, 1'b0, 32'h3F00_0000, 4);
    run_op(32'h4000_0000, 32'hC000_0000, 1'b0, 32'h0000_0000, 2);
    run_op(32'h0000_0000, 32'h4040_0000, 1'b0, 32'h4040_0000, 2);
    run_op(32'h4040_0000, 32'h0000_0000, 1'b0, 32'h4040_0000, 2);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 2);
    run_op(32'h3F80_0000, 32'h3F00_0000, 1'b0, 32'h3FC0_0000, 3);
    run_op(32'h3F80_0000, 32'hBF40_0000, 1'b0, 32'h3E80_0000, 5);
    run_op(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3);
    run_op(32'hBF80_0000, 32'hBF80_0000, 1'b0, 32'hC000_0000, 3);
    run_op(32'h80C0_0000, 32'h0080_0000, 1'b0, 32'h8000_0000, 4);

    // Overflow to infinity with back-pressure held for 5 cycles.
    out_ready = 1'b0;
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3);
    wait_out(1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 32'h3F80_0000; b = 32'h3F80_0000;
      @(negedge clk);
      check("hold_result", result, 32'h7F80_0000);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_out(1'b0);

    // Reset in the middle of a long NORM sequence.
    issue(32'h3F80_0001, 32'hBF80_0000, 1'b0, 32'h0, 0);
    void'(sb_q.pop_back());
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midnorm_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midnorm_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midnorm_rst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3);

`ifdef FP_SEQ_ADDER_SUB_EN
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 2);
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3);
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_seq_adder.md
FP_SEQ_ADDER -- requirements
Module: fp_seq_adder

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width (hidden bit excluded); word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands a/b valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  W  operand A, {sign, exponent, mantissa}.
REQ-008 b  input  W  operand B, same format.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  W  sum, same format.

Function
REQ-012 SHALL implement FSM with states IDLE, ALIGN, ADD, NORM, DONE; exactly one operation in flight.
REQ-013 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready at a rising edge; a/b (and sub, if present) captured into internal registers at accept; IDLE->ALIGN.
REQ-014 ALIGN: larger-magnitude operand (exponent, then mantissa compare; tie -> B larger) becomes L, other S; d = expL - expS; S mantissa (hidden 1 prepended) right-shifted by d; d > MAN_W yields shifted S = 0; ALIGN->ADD.
REQ-015 ALIGN special cases, resolved directly to DONE: either exponent field 0 -> operand treated as zero, result = other operand unchanged (both zero -> all-zero); equal magnitude with opposite effective signs -> result all-zero.
REQ-016 ADD: same effective signs -> mantissas added (MAN_W+2 bits incl. carry); else L - S; result sign = sign of L; working exponent = expL.
REQ-017 ADD carry out SHALL shift mantissa right 1, exponent +1; if exponent reaches all-ones, result = signed infinity (exponent all-ones, mantissa 0); -> DONE.
REQ-018 ADD with hidden-bit position set -> DONE; otherwise -> NORM.
REQ-019 NORM: one left shift and exponent -1 per cycle until hidden bit set (-> DONE); if exponent would drop to 0 before that, result = signed zero, -> DONE.
REQ-020 Rounding SHALL be truncation; bits shifted out are discarded.
REQ-021 DONE: out_valid = 1, result stable; on out_valid & out_ready -> IDLE; out_valid low next cycle.
REQ-022 Latency, accept edge to out_valid: 2 cycles for REQ-015 cases, 3 cycles normal, 3+k with k NORM shifts (k <= MAN_W).
REQ-023 in_valid/a/b changes outside IDLE SHALL be ignored.
REQ-024 out_ready low in DONE SHALL hold result and out_valid indefinitely.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, in_ready 1, out_valid 0, result 0, internal registers 0, regardless of state (including mid-NORM).
REQ-026 First accept possible at first rising edge with rst_n high.

Configuration
REQ-027 With macro FP_SEQ_ADDER_SUB_EN defined: extra port sub input 1, captured at accept; sub=1 computes a - b (B sign inverted before ALIGN).
REQ-028 Without FP_SEQ_ADDER_SUB_EN: no sub port; always a + b.

Verification
REQ-029 Reset, then a=0x3F800000, b=0x3F800000 -> result 0x40000000, out_valid 3 cycles after accept.
REQ-030 a=0x3FC00000, b=0xBF800000 -> result 0x3F000000, one NORM shift, latency 4.
REQ-031 a=0x40000000, b=0xC0000000 -> 0x00000000 latency 2; a=0x00000000, b=0x40400000 -> 0x40400000 latency 2.
REQ-032 a=0x7F7FFFFF, b=0x7F7FFFFF -> 0x7F800000; out_ready held low 5 cycles -> result/out_valid stable, in_ready 0, in_valid pulses ignored.
REQ-033 rst_n pulsed low during NORM of a=0x3F800001, b=0xBF800000 -> outputs at reset values immediately; next op 1.0+1.0 correct.
REQ-034 FP_SEQ_ADDER_SUB_EN defined: a=0x3F800000, b=0x3F800000, sub=1 -> 0x00000000; sub=0 -> 0x40000000.
